// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding, default address field geometry and address split helpers.
package icache_pkg;

  localparam int ICACHE_INDEX = 6;
  localparam int ICACHE_OFFS  = 2;
  localparam int ICACHE_ADDR  = 32;
  localparam int ITAGLSB      = ICACHE_INDEX + ICACHE_OFFS;
  localparam int ITAGMSB      = ICACHE_ADDR - 1;
  localparam int ICACHE_TAG   = ITAGMSB - ITAGLSB + 1;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    UPDATE = 2'd3
  } icache_state_t;

  function automatic logic [ICACHE_TAG-1:0] get_tag(input logic [ICACHE_ADDR-1:0] addr);
    return addr[ITAGMSB:ITAGLSB];
  endfunction

  function automatic logic [ICACHE_INDEX-1:0] get_index(input logic [ICACHE_ADDR-1:0] addr);
    return addr[ITAGLSB-1:ICACHE_OFFS];
  endfunction

  function automatic logic [ICACHE_OFFS-1:0] get_offset(input logic [ICACHE_ADDR-1:0] addr);
    return addr[ICACHE_OFFS-1:0];
  endfunction

endpackage

// File: rtl/icache_addr_split.sv
// Combinational split of a word address into {tag, index, offset}; shared by
// the cache controller and the data RAM wrapper.
module icache_addr_split
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX,
  parameter int TAG_W   = ICACHE_TAG,
  parameter int OFFS_W  = ICACHE_OFFS,
  parameter int ADDR_W  = ICACHE_ADDR
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [TAG_W-1:0]   tag,
  output logic [INDEX_W-1:0] index,
  output logic [OFFS_W-1:0]  offset
);

  assign offset = addr[OFFS_W-1:0];
  assign index  = addr[OFFS_W +: INDEX_W];
  assign tag    = addr[OFFS_W+INDEX_W +: TAG_W];

endmodule

// File: rtl/inst_cache_ctrl.sv
// Instruction cache sequencing controller: tag lookup, line refill, tag update
// and full invalidation sweep. Optional hit/miss counters under ICACHE_STATS_EN.
module inst_cache_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX,
  parameter int TAG_W   = ICACHE_TAG,
  parameter int OFFS_W  = ICACHE_OFFS,
  parameter int ADDR_W  = ICACHE_ADDR
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  input  logic [ADDR_W-1:0]         cpu_addr,
  output logic                      cpu_ready,
  output logic                      stall,
  input  logic                      flush_req,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  output logic                      tag_we,
  output logic [INDEX_W-1:0]        tag_index,
  output logic                      tag_valid_wr,
  output logic [TAG_W-1:0]          tag_wr,
  input  logic                      tag_valid_rd,
  input  logic [TAG_W-1:0]          tag_rd,
  output logic                      data_we,
  output logic [INDEX_W+OFFS_W-1:0] data_waddr,
  output logic [1:0]                state_dbg
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  // ADDR_W is expected to equal TAG_W + INDEX_W + OFFS_W.
  localparam logic [INDEX_W-1:0] LAST_INDEX = '1;
  localparam logic [OFFS_W-1:0]  LAST_BEAT  = '1;

  icache_state_t state_q, state_d;
  logic [INDEX_W-1:0] flush_ctr_q;
  logic [OFFS_W-1:0]  beat_q;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [INDEX_W-1:0] miss_index_q;
  logic               flush_pend_q;
  logic               hit;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [OFFS_W-1:0]  unused_offset;

  icache_addr_split #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .OFFS_W  (OFFS_W),
    .ADDR_W  (ADDR_W)
  ) u_split (
    .addr   (cpu_addr),
    .tag    (req_tag),
    .index  (req_index),
    .offset (unused_offset)
  );

  always_comb begin
    state_d      = state_q;
    hit          = 1'b0;
    cpu_ready    = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    tag_we       = 1'b0;
    tag_index    = '0;
    tag_valid_wr = 1'b0;
    tag_wr       = '0;
    data_we      = 1'b0;
    data_waddr   = '0;
    case (state_q)
      FLUSH: begin
        tag_we    = 1'b1;
        tag_index = flush_ctr_q;
        stall     = 1'b1;
        if (flush_ctr_q == LAST_INDEX) state_d = LOOKUP;
      end
      LOOKUP: begin
        tag_index = req_index;
        hit       = cpu_req & tag_valid_rd & (tag_rd == req_tag);
        cpu_ready = hit;
        stall     = cpu_req & ~hit;
        // A flush wins over a new miss; a same-cycle hit still completes.
        if (flush_req)            state_d = FLUSH;
        else if (cpu_req && !hit) state_d = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, miss_index_q, beat_q};
        stall    = 1'b1;
        if (mem_ack) begin
          data_we    = 1'b1;
          data_waddr = {miss_index_q, beat_q};
          if (beat_q == LAST_BEAT) state_d = UPDATE;
        end
      end
      UPDATE: begin
        tag_we       = 1'b1;
        tag_index    = miss_index_q;
        tag_valid_wr = 1'b1;
        tag_wr       = miss_tag_q;
        stall        = 1'b1;
        state_d      = (flush_pend_q || flush_req) ? FLUSH : LOOKUP;
      end
      default: state_d = FLUSH;
    endcase
    // Outputs are held quiet for the whole reset cycle, including mid-refill.
    if (!reset_n) begin
      hit          = 1'b0;
      cpu_ready    = 1'b0;
      stall        = 1'b0;
      mem_req      = 1'b0;
      mem_addr     = '0;
      tag_we       = 1'b0;
      tag_index    = '0;
      tag_valid_wr = 1'b0;
      tag_wr       = '0;
      data_we      = 1'b0;
      data_waddr   = '0;
    end
  end

  assign state_dbg = reset_n ? state_q : 2'b00;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= FLUSH;
      flush_ctr_q  <= '0;
      beat_q       <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FLUSH) flush_ctr_q <= flush_ctr_q + 1'b1;
      else                  flush_ctr_q <= '0;
      if (state_q == LOOKUP && state_d == REFILL) begin
        miss_tag_q   <= req_tag;
        miss_index_q <= req_index;
        beat_q       <= '0;
      end else if (state_q == REFILL && mem_ack) begin
        beat_q <= beat_q + 1'b1;
      end
      if (state_q == UPDATE)                    flush_pend_q <= 1'b0;
      else if (state_q == REFILL && flush_req)  flush_pend_q <= 1'b1;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (state_q == LOOKUP && state_d == REFILL && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Scoreboard bench for inst_cache_ctrl with a tag RAM / memory environment and
// a line-level cache model. Build with ICACHE_STATS_EN to cover the counters.
module tb_inst_cache_ctrl;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 24;
  localparam int OFFS_W  = 2;
  localparam int ADDR_W  = 32;
  localparam int LINES   = 1 << INDEX_W;

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      cpu_req = 1'b0;
  logic [ADDR_W-1:0]         cpu_addr = '0;
  logic                      cpu_ready, stall;
  logic                      flush_req = 1'b0;
  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_ack = 1'b0;
  logic                      tag_we;
  logic [INDEX_W-1:0]        tag_index;
  logic                      tag_valid_wr;
  logic [TAG_W-1:0]          tag_wr;
  logic                      tag_valid_rd;
  logic [TAG_W-1:0]          tag_rd;
  logic                      data_we;
  logic [INDEX_W+OFFS_W-1:0] data_waddr;
  logic [1:0]                state_dbg;
`ifdef ICACHE_STATS_EN
  logic [31:0]               hit_count, miss_count;
`endif

  inst_cache_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_ready    (cpu_ready),
    .stall        (stall),
    .flush_req    (flush_req),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .tag_we       (tag_we),
    .tag_index    (tag_index),
    .tag_valid_wr (tag_valid_wr),
    .tag_wr       (tag_wr),
    .tag_valid_rd (tag_valid_rd),
    .tag_rd       (tag_rd),
    .data_we      (data_we),
    .data_waddr   (data_waddr),
    .state_dbg    (state_dbg)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- environment: tag RAM and memory port ----------------
  logic             tram_v [LINES];
  logic [TAG_W-1:0] tram_t [LINES];
  assign tag_valid_rd = tram_v[tag_index];
  assign tag_rd       = tram_t[tag_index];

  always @(posedge clock) begin
    if (tag_we) begin
      tram_v[tag_index] <= tag_valid_wr;
      tram_t[tag_index] <= tag_wr;
    end
  end

  int ack_gap = 0;
  int gcnt = 0;
  always @(posedge clock) begin
    #1;
    if (mem_req) begin
      if (gcnt >= ack_gap) begin mem_ack = 1'b1; gcnt = 0; end
      else begin mem_ack = 1'b0; gcnt++; end
    end else begin
      mem_ack = 1'b0;
      gcnt = 0;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic             m_valid [LINES];
  logic [TAG_W-1:0] m_tag   [LINES];
  logic [31:0] mem_exp_q[$];
  logic [31:0] tagw_exp_q[$];
  logic [31:0] ready_exp_q[$];
  int exp_sweeps = 0, sweeps_done = 0, sweep_idx = 0;
  int n_hit_exp = 0, n_miss_exp = 0;
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (1 << OFFS_W)) % LINES);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return TAG_W'(a / (1 << (OFFS_W + INDEX_W)));
  endfunction

  function automatic void expect_miss(input logic [31:0] a);
    logic [31:0] base;
    base = a - (a % (1 << OFFS_W));
    for (int b = 0; b < (1 << OFFS_W); b++) mem_exp_q.push_back(base + 32'(b));
    tagw_exp_q.push_back({2'b00, 6'(idx_of(a)), tag_of(a)});
    m_valid[idx_of(a)] = 1'b1;
    m_tag[idx_of(a)]   = tag_of(a);
    n_miss_exp++;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [31:0] e;
    if (!reset_n) begin
      chk("reset_outputs_zero", 64'(|{cpu_ready, stall, mem_req, mem_addr, tag_we, tag_index,
          tag_valid_wr, tag_wr, data_we, data_waddr}), 64'd0);
      sweep_idx = 0;
    end else begin
      if (mem_req && mem_ack) begin
        chk("mem_q_nonempty", 64'(mem_exp_q.size() != 0), 64'd1);
        if (mem_exp_q.size() != 0) begin
          e = mem_exp_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(e));
          chk("data_we", 64'(data_we), 64'd1);
          chk("data_waddr", 64'(data_waddr), 64'(e[7:0]));
        end
      end else if (data_we) begin
        chk("data_we_no_ack", 64'(data_we), 64'd0);
      end
      if (tag_we && tag_valid_wr) begin
        chk("tagw_q_nonempty", 64'(tagw_exp_q.size() != 0), 64'd1);
        if (tagw_exp_q.size() != 0) begin
          e = tagw_exp_q.pop_front();
          chk("tag_update", 64'({2'b00, tag_index, tag_wr}), 64'(e));
        end
      end
      if (tag_we && !tag_valid_wr) begin
        chk("sweep_index", 64'(tag_index), 64'(sweep_idx));
        chk("sweep_tag_zero", 64'(tag_wr), 64'd0);
        chk("sweep_stall", 64'(stall), 64'd1);
        sweep_idx++;
        if (sweep_idx == LINES) begin sweeps_done++; sweep_idx = 0; end
      end else if (sweep_idx != 0) begin
        chk("sweep_contiguous", 64'(tag_we), 64'd1);
        sweep_idx = 0;
      end
      if (cpu_ready) begin
        chk("ready_q_nonempty", 64'(ready_exp_q.size() != 0), 64'd1);
        if (ready_exp_q.size() != 0) begin
          e = ready_exp_q.pop_front();
          chk("ready_addr", 64'(cpu_addr), 64'(e));
        end
        chk("ready_no_stall", 64'(stall), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_sweep();
    int t = 0;
    while (sweeps_done < exp_sweeps && t < 400) begin cyc(1); t++; end
    chk("sweep_done", 64'(sweeps_done), 64'(exp_sweeps));
    @(negedge clock);
    chk("post_sweep_stall", 64'(stall), 64'd0);
    chk("post_sweep_state", 64'(state_dbg), 64'd1);
    @(posedge clock); #1;
  endtask

  // flush_at >= 0 pulses flush_req that many cycles after the miss cycle.
  task automatic fetch(input logic [31:0] a, input int gap, input int flush_at);
    bit hit;
    int lat = 0;
    ack_gap = gap;
    hit = m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    if (!hit) begin
      expect_miss(a);
      if (flush_at >= 0) begin
        model_flush();
        exp_sweeps++;
        expect_miss(a);
      end
    end
    n_hit_exp++;
    ready_exp_q.push_back(a);
    cpu_req  = 1'b1;
    cpu_addr = a;
    forever begin
      @(negedge clock);
      if (cpu_ready || lat >= 2000) break;
      @(posedge clock); #1;
      lat++;
      flush_req = (lat == flush_at);
    end
    chk("fetch_completed", 64'(lat < 2000), 64'd1);
    if (hit) chk("hit_latency", 64'(lat), 64'd0);
    else if (gap == 0 && flush_at < 0) chk("miss_latency", 64'(lat), 64'd6);
    @(posedge clock); #1;
    cpu_req   = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic idle_flush();
    flush_req = 1'b1;
    cyc(1);
    flush_req = 1'b0;
    model_flush();
    exp_sweeps++;
    wait_sweep();
  endtask

  task automatic hit_with_flush(input logic [31:0] a);
    ready_exp_q.push_back(a);
    n_hit_exp++;
    cpu_req = 1'b1; cpu_addr = a; flush_req = 1'b1;
    @(negedge clock);
    chk("flush_cycle_hit", 64'(cpu_ready), 64'd1);
    @(posedge clock); #1;
    cpu_req = 1'b0; flush_req = 1'b0;
    model_flush();
    exp_sweeps++;
    wait_sweep();
  endtask

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    @(negedge clock);
    chk("hit_count", 64'(hit_count), 64'(n_hit_exp));
    chk("miss_count", 64'(miss_count), 64'(n_miss_exp));
    @(posedge clock); #1;
`endif
  endtask

  task automatic reset_mid_refill(input logic [31:0] a);
    ack_gap = 6;
    cpu_req = 1'b1; cpu_addr = a;
    cyc(3);
    chk("in_refill_before_reset", 64'(state_dbg), 64'd2);
    reset_n = 1'b0; cpu_req = 1'b0;
    @(negedge clock);
    chk("reset_drops_mem_req", 64'(mem_req), 64'd0);
    @(posedge clock); #1;
    cyc(1);
    model_flush();
    n_hit_exp = 0; n_miss_exp = 0;
    exp_sweeps++;
    reset_n = 1'b1;
    wait_sweep();
  endtask

  // ---------------- test sequence ----------------
  logic [TAG_W-1:0] tag_pool [3];
  int               idx_pool [4];

  initial begin
    logic [31:0] a;
    for (int i = 0; i < LINES; i++) begin
      tram_v[i] = 1'($urandom_range(0, 1));
      tram_t[i] = TAG_W'($urandom);
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    tag_pool = '{24'h000012, 24'h000022, 24'h5A5A01};
    idx_pool = '{13, 13, 1, 63};

    reset_n = 1'b0;
    cyc(3);
    exp_sweeps = 1;
    reset_n = 1'b1;
    wait_sweep();
    check_stats();

    fetch(32'h0000_1234, 0, -1);
    fetch(32'h0000_1235, 0, -1);
    fetch(32'h0000_2234, 0, -1);
    fetch(32'h0000_1234, 0, -1);
    fetch(32'h0000_2236, 3, 5);
    fetch(32'h0000_1234, 0, -1);
    hit_with_flush(32'h0000_1237);
    fetch(32'h0000_1234, 0, -1);
    for (int i = 0; i < 5; i++) fetch(32'h0000_1234 + 32'(i % 4), 0, -1);
    check_stats();
    idle_flush();
    check_stats();

    for (int i = 0; i < 40; i++) begin
      a = {tag_pool[$urandom_range(0, 2)], 6'(idx_pool[$urandom_range(0, 3)]),
           2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) idle_flush();
      fetch(a, $urandom_range(0, 2), -1);
      cyc($urandom_range(0, 2));
    end
    check_stats();

    reset_mid_refill(32'h0000_3300);
    check_stats();
    fetch(32'h0000_3300, 0, -1);
    fetch(32'h0000_3301, 1, -1);
    check_stats();

    cyc(4);
    chk("mem_q_drained", 64'(mem_exp_q.size()), 64'd0);
    chk("tagw_q_drained", 64'(tagw_exp_q.size()), 64'd0);
    chk("ready_q_drained", 64'(ready_exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
